// File: rtl/axis_dot_arbiter.sv
// axis_dot_arbiter: round-robin arbiter that shares one dot-product engine
// between two AXI4-Stream requesters. A grant covers one request packet sent
// to the engine and the matching result packet routed back to the requester.
//
// Ports:
//   aclk, areset               clock, asynchronous active-high reset
//   S0_AXIS_*, S1_AXIS_*       requester input vectors (slave side)
//   M0_AXIS_*, M1_AXIS_*       result vectors back to each requester
//   ENG_IN_AXIS_*              to the engine input stream
//   ENG_OUT_AXIS_*             from the engine output stream
//   busy                       high while a transaction is in flight
//   grant                      owning requester index, valid while busy
//   len_err                    sticky packet-length violation flag
module axis_dot_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4
) (
  input  logic              aclk,
  input  logic              areset,

  input  logic [DATA_W-1:0] S0_AXIS_TDATA,
  input  logic              S0_AXIS_TLAST,
  input  logic              S0_AXIS_TVALID,
  output logic              S0_AXIS_TREADY,

  input  logic [DATA_W-1:0] S1_AXIS_TDATA,
  input  logic              S1_AXIS_TLAST,
  input  logic              S1_AXIS_TVALID,
  output logic              S1_AXIS_TREADY,

  output logic [DATA_W-1:0] M0_AXIS_TDATA,
  output logic              M0_AXIS_TLAST,
  output logic              M0_AXIS_TVALID,
  input  logic              M0_AXIS_TREADY,

  output logic [DATA_W-1:0] M1_AXIS_TDATA,
  output logic              M1_AXIS_TLAST,
  output logic              M1_AXIS_TVALID,
  input  logic              M1_AXIS_TREADY,

  output logic [DATA_W-1:0] ENG_IN_AXIS_TDATA,
  output logic              ENG_IN_AXIS_TLAST,
  output logic              ENG_IN_AXIS_TVALID,
  input  logic              ENG_IN_AXIS_TREADY,

  input  logic [DATA_W-1:0] ENG_OUT_AXIS_TDATA,
  input  logic              ENG_OUT_AXIS_TLAST,
  input  logic              ENG_OUT_AXIS_TVALID,
  output logic              ENG_OUT_AXIS_TREADY,

  output logic              busy,
  output logic              grant,
  output logic              len_err
);

  localparam int unsigned IN_W  = $clog2(ROWS + 1);
  localparam int unsigned OUT_W = $clog2(COLS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [IN_W-1:0]  in_cnt_q, in_cnt_d;
  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
  logic             len_err_q, len_err_d;
  logic             busy_q;

  logic             in_sel0, in_sel1, out_sel0, out_sel1;
  logic             in_hs, out_hs;
  logic [IN_W-1:0]  in_cnt_inc;
  logic [OUT_W-1:0] out_cnt_inc;

  // Path selects decoded from registered state and grant only.
  assign in_sel0  = (state_q == ST_SEND) && !grant_q;
  assign in_sel1  = (state_q == ST_SEND) &&  grant_q;
  assign out_sel0 = (state_q == ST_RECV) && !grant_q;
  assign out_sel1 = (state_q == ST_RECV) &&  grant_q;

  // Request path: granted requester straight through to the engine.
  assign ENG_IN_AXIS_TVALID = (in_sel0 && S0_AXIS_TVALID) || (in_sel1 && S1_AXIS_TVALID);
  assign ENG_IN_AXIS_TLAST  = (in_sel0 && S0_AXIS_TLAST)  || (in_sel1 && S1_AXIS_TLAST);
  assign ENG_IN_AXIS_TDATA  = in_sel0 ? S0_AXIS_TDATA :
                              (in_sel1 ? S1_AXIS_TDATA : '0);
  assign S0_AXIS_TREADY     = in_sel0 && ENG_IN_AXIS_TREADY;
  assign S1_AXIS_TREADY     = in_sel1 && ENG_IN_AXIS_TREADY;

  // Result path: engine output steered to the granted requester.
  assign M0_AXIS_TVALID      = out_sel0 && ENG_OUT_AXIS_TVALID;
  assign M0_AXIS_TLAST       = out_sel0 && ENG_OUT_AXIS_TLAST;
  assign M0_AXIS_TDATA       = out_sel0 ? ENG_OUT_AXIS_TDATA : '0;
  assign M1_AXIS_TVALID      = out_sel1 && ENG_OUT_AXIS_TVALID;
  assign M1_AXIS_TLAST       = out_sel1 && ENG_OUT_AXIS_TLAST;
  assign M1_AXIS_TDATA       = out_sel1 ? ENG_OUT_AXIS_TDATA : '0;
  assign ENG_OUT_AXIS_TREADY = (out_sel0 && M0_AXIS_TREADY) || (out_sel1 && M1_AXIS_TREADY);

  assign in_hs  = ENG_IN_AXIS_TVALID  && ENG_IN_AXIS_TREADY;
  assign out_hs = ENG_OUT_AXIS_TVALID && ENG_OUT_AXIS_TREADY;

  // Counters saturate so an overlong packet cannot wrap back to a legal length.
  assign in_cnt_inc  = (&in_cnt_q)  ? in_cnt_q  : in_cnt_q  + IN_W'(1);
  assign out_cnt_inc = (&out_cnt_q) ? out_cnt_q : out_cnt_q + OUT_W'(1);

  assign busy    = busy_q;
  assign grant   = grant_q;
  assign len_err = len_err_q;

  // Next-state: arbitration, packet framing and length checking.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    len_err_d    = len_err_q;
    case (state_q)
      ST_IDLE: begin
        if (S0_AXIS_TVALID || S1_AXIS_TVALID) begin
          // On a tie the requester that did not own the last grant wins.
          grant_d      = (S0_AXIS_TVALID && S1_AXIS_TVALID) ? !last_grant_q : S1_AXIS_TVALID;
          last_grant_d = grant_d;
          in_cnt_d     = '0;
          out_cnt_d    = '0;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (in_hs) begin
          in_cnt_d = in_cnt_inc;
          if (ENG_IN_AXIS_TLAST) begin
            state_d = ST_RECV;
            if (in_cnt_inc != IN_W'(ROWS)) len_err_d = 1'b1;
          end else if (in_cnt_q == IN_W'(ROWS)) begin
            // Word ROWS+1 arrived without TLAST; keep forwarding but flag it.
            len_err_d = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (out_hs) begin
          out_cnt_d = out_cnt_inc;
          if (ENG_OUT_AXIS_TLAST) begin
            state_d = ST_IDLE;
            if (out_cnt_inc != OUT_W'(COLS)) len_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      len_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      len_err_q    <= len_err_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_axis_dot_arbiter.sv
// Directed bench for axis_dot_arbiter. A small engine stand-in accepts one
// packet, then returns four words: sum(inputs)+k, TLAST on k=3.
module tb_axis_dot_arbiter;

  localparam int unsigned DW = 32;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [DW-1:0] S0_AXIS_TDATA, S1_AXIS_TDATA, M0_AXIS_TDATA, M1_AXIS_TDATA;
  logic S0_AXIS_TLAST, S0_AXIS_TVALID, S0_AXIS_TREADY;
  logic S1_AXIS_TLAST, S1_AXIS_TVALID, S1_AXIS_TREADY;
  logic M0_AXIS_TLAST, M0_AXIS_TVALID, M0_AXIS_TREADY;
  logic M1_AXIS_TLAST, M1_AXIS_TVALID, M1_AXIS_TREADY;
  logic [DW-1:0] ENG_IN_AXIS_TDATA, ENG_OUT_AXIS_TDATA;
  logic ENG_IN_AXIS_TLAST, ENG_IN_AXIS_TVALID, ENG_IN_AXIS_TREADY;
  logic ENG_OUT_AXIS_TLAST, ENG_OUT_AXIS_TVALID, ENG_OUT_AXIS_TREADY;
  logic busy, grant, len_err;

  logic m1_rdy, tog_en, tog;
  assign M0_AXIS_TREADY = 1'b1;
  assign M1_AXIS_TREADY = tog_en ? tog : m1_rdy;
  always @(posedge aclk) tog <= ~tog;

  axis_dot_arbiter #(.DATA_W(DW), .ROWS(4), .COLS(4)) dut (
    .aclk(aclk), .areset(areset),
    .S0_AXIS_TDATA(S0_AXIS_TDATA), .S0_AXIS_TLAST(S0_AXIS_TLAST),
    .S0_AXIS_TVALID(S0_AXIS_TVALID), .S0_AXIS_TREADY(S0_AXIS_TREADY),
    .S1_AXIS_TDATA(S1_AXIS_TDATA), .S1_AXIS_TLAST(S1_AXIS_TLAST),
    .S1_AXIS_TVALID(S1_AXIS_TVALID), .S1_AXIS_TREADY(S1_AXIS_TREADY),
    .M0_AXIS_TDATA(M0_AXIS_TDATA), .M0_AXIS_TLAST(M0_AXIS_TLAST),
    .M0_AXIS_TVALID(M0_AXIS_TVALID), .M0_AXIS_TREADY(M0_AXIS_TREADY),
    .M1_AXIS_TDATA(M1_AXIS_TDATA), .M1_AXIS_TLAST(M1_AXIS_TLAST),
    .M1_AXIS_TVALID(M1_AXIS_TVALID), .M1_AXIS_TREADY(M1_AXIS_TREADY),
    .ENG_IN_AXIS_TDATA(ENG_IN_AXIS_TDATA), .ENG_IN_AXIS_TLAST(ENG_IN_AXIS_TLAST),
    .ENG_IN_AXIS_TVALID(ENG_IN_AXIS_TVALID), .ENG_IN_AXIS_TREADY(ENG_IN_AXIS_TREADY),
    .ENG_OUT_AXIS_TDATA(ENG_OUT_AXIS_TDATA), .ENG_OUT_AXIS_TLAST(ENG_OUT_AXIS_TLAST),
    .ENG_OUT_AXIS_TVALID(ENG_OUT_AXIS_TVALID), .ENG_OUT_AXIS_TREADY(ENG_OUT_AXIS_TREADY),
    .busy(busy), .grant(grant), .len_err(len_err)
  );

  // Engine stand-in: collect a packet, then emit sum+0..sum+3.
  logic          eng_out_mode;
  logic [DW-1:0] eng_sum;
  logic [2:0]    eng_idx;
  assign ENG_IN_AXIS_TREADY  = !eng_out_mode;
  assign ENG_OUT_AXIS_TVALID = eng_out_mode;
  assign ENG_OUT_AXIS_TDATA  = eng_sum + 32'(eng_idx);
  assign ENG_OUT_AXIS_TLAST  = eng_out_mode && (eng_idx == 3'd3);
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      eng_out_mode <= 1'b0; eng_sum <= '0; eng_idx <= '0;
    end else if (!eng_out_mode) begin
      if (ENG_IN_AXIS_TVALID && ENG_IN_AXIS_TREADY) begin
        eng_sum <= eng_sum + ENG_IN_AXIS_TDATA;
        if (ENG_IN_AXIS_TLAST) begin eng_out_mode <= 1'b1; eng_idx <= '0; end
      end
    end else if (ENG_OUT_AXIS_TREADY) begin
      if (eng_idx == 3'd3) begin eng_out_mode <= 1'b0; eng_sum <= '0; eng_idx <= '0; end
      else eng_idx <= eng_idx + 3'd1;
    end
  end

  // Monitor (negedge, away from the active edge).
  logic [DW-1:0] m0_d[$], m1_d[$];
  logic          m0_l[$], m1_l[$];
  int   viol, bp_viol, m1v_cnt, gn, gap_last, idle_run;
  logic [15:0] gbits;
  logic busy_prev, pend_b, busy_at_last, busy_after, pend_le, le_before, le_after;

  always @(negedge aclk) begin
    if (pend_b) begin busy_after = busy; pend_b = 1'b0; end
    if (pend_le) begin le_after = len_err; pend_le = 1'b0; end
    if (M0_AXIS_TVALID && M0_AXIS_TREADY) begin
      m0_d.push_back(M0_AXIS_TDATA); m0_l.push_back(M0_AXIS_TLAST);
      if (M0_AXIS_TLAST) begin busy_at_last = busy; pend_b = 1'b1; end
    end
    if (M1_AXIS_TVALID && M1_AXIS_TREADY) begin
      m1_d.push_back(M1_AXIS_TDATA); m1_l.push_back(M1_AXIS_TLAST);
      if (M1_AXIS_TLAST) begin busy_at_last = busy; pend_b = 1'b1; end
    end
    if (ENG_IN_AXIS_TVALID && ENG_IN_AXIS_TREADY && ENG_IN_AXIS_TLAST) begin
      le_before = len_err; pend_le = 1'b1;
    end
    if (M1_AXIS_TVALID) m1v_cnt++;
    if ((S0_AXIS_TREADY && !(busy && !grant)) || (S1_AXIS_TREADY && !(busy && grant)) ||
        (M0_AXIS_TVALID && !(busy && !grant)) || (M1_AXIS_TVALID && !(busy && grant)))
      viol++;
    if (ENG_OUT_AXIS_TVALID && ENG_OUT_AXIS_TREADY &&
        !((M0_AXIS_TVALID && M0_AXIS_TREADY) || (M1_AXIS_TVALID && M1_AXIS_TREADY)))
      bp_viol++;
    if (busy && !busy_prev) begin
      gbits = {gbits[14:0], grant}; gn++; gap_last = idle_run;
    end
    idle_run  = busy ? 0 : idle_run + 1;
    busy_prev = busy;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    m0_d.delete(); m1_d.delete(); m0_l.delete(); m1_l.delete();
    viol = 0; bp_viol = 0; m1v_cnt = 0; gn = 0; gbits = '0; gap_last = 0;
    pend_b = 1'b0; pend_le = 1'b0; busy_at_last = 1'b0; busy_after = 1'b1;
    le_before = 1'bx; le_after = 1'bx;
  endtask

  task automatic set_s(input int p, input logic v, input logic [DW-1:0] d, input logic l);
    if (p == 0) begin S0_AXIS_TVALID = v; S0_AXIS_TDATA = d; S0_AXIS_TLAST = l; end
    else        begin S1_AXIS_TVALID = v; S1_AXIS_TDATA = d; S1_AXIS_TLAST = l; end
  endtask

  // Send words base+0..base+n-1, TLAST on the last; optional 2-cycle gaps.
  task automatic drive_s(input int p, input int n, input logic [DW-1:0] base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int  t;
      logic hs;
      if (gaps && i > 0) begin
        set_s(p, 1'b0, '0, 1'b0);
        repeat (2) @(posedge aclk);
        #1;
      end
      set_s(p, 1'b1, base + DW'(i), (i == n - 1));
      t = 0; hs = 1'b0;
      while (!hs && t < 300) begin
        @(negedge aclk);
        hs = (p == 0) ? S0_AXIS_TREADY : S1_AXIS_TREADY;
        @(posedge aclk); #1;
        t++;
      end
      chk($sformatf("p%0d_word%0d_handshake", p, i), 64'(hs), 64'd1);
    end
    set_s(p, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_words(input int p, input int n);
    int t = 0;
    while (((p == 0) ? m0_d.size() : m1_d.size()) < n && t < 600) begin
      @(posedge aclk); t++;
    end
    repeat (3) @(posedge aclk);
    #1;
    chk($sformatf("p%0d_word_count", p), 64'((p == 0) ? m0_d.size() : m1_d.size()), 64'(n));
  endtask

  // Four result words starting at queue index idx: sum+k, TLAST on k=3.
  task automatic chk_pkt(input int p, input int idx, input logic [DW-1:0] sum);
    for (int k = 0; k < 4; k++) begin
      if (p == 0) begin
        chk($sformatf("m0_data[%0d]", idx + k), 64'(m0_d[idx + k]), 64'(sum + DW'(k)));
        chk($sformatf("m0_last[%0d]", idx + k), 64'(m0_l[idx + k]), 64'(k == 3));
      end else begin
        chk($sformatf("m1_data[%0d]", idx + k), 64'(m1_d[idx + k]), 64'(sum + DW'(k)));
        chk($sformatf("m1_last[%0d]", idx + k), 64'(m1_l[idx + k]), 64'(k == 3));
      end
    end
  endtask

  function automatic logic [5:0] hs_vec();
    return {S0_AXIS_TREADY, S1_AXIS_TREADY, M0_AXIS_TVALID, M1_AXIS_TVALID,
            ENG_IN_AXIS_TVALID, ENG_OUT_AXIS_TREADY};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    areset = 1'b1; m1_rdy = 1'b1; tog_en = 1'b0; tog = 1'b0;
    busy_prev = 1'b0; idle_run = 0;
    set_s(0, 1'b0, '0, 1'b0);
    set_s(1, 1'b0, '0, 1'b0);
    clr();
    repeat (3) @(posedge aclk);
    #1;
    // Reset state.
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_hs_vec", 64'(hs_vec()), 64'd0);
    areset = 1'b0;
    @(posedge aclk); #1;

    // Single request from S0: 1,2,3,4 -> sum 10.
    clr();
    drive_s(0, 4, 32'd1, 1'b0);
    wait_words(0, 4);
    chk_pkt(0, 0, 32'd10);
    chk("t1_m1_valid_cycles", 64'(m1v_cnt), 64'd0);
    chk("t1_len_err", 64'(len_err), 64'd0);
    chk("t1_busy_at_last", 64'(busy_at_last), 64'd1);
    chk("t1_busy_after_last", 64'(busy_after), 64'd0);
    chk("t1_grant", 64'(gbits[0]), 64'd0);
    chk("t1_viol", 64'(viol), 64'd0);

    // Simultaneous requests after reset: S0 first, S1 one idle cycle later.
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    clr();
    fork
      drive_s(0, 4, 32'd16, 1'b0);
      drive_s(1, 4, 32'd256, 1'b0);
    join
    wait_words(1, 4);
    chk("t2_grant_count", 64'(gn), 64'd2);
    chk("t2_grant_order", 64'(gbits[1:0]), 64'b01);
    chk("t2_idle_gap", 64'(gap_last), 64'd1);
    chk_pkt(0, 0, 32'd70);
    chk_pkt(1, 0, 32'd1030);
    chk("t2_viol", 64'(viol), 64'd0);

    // Fairness: three back-to-back packets per requester.
    clr();
    fork
      for (int k = 0; k < 3; k++) drive_s(0, 4, 32'h1000 * DW'(k + 1), 1'b0);
      for (int k = 0; k < 3; k++) drive_s(1, 4, 32'h10000 * DW'(k + 1), 1'b0);
    join
    wait_words(0, 12);
    wait_words(1, 12);
    chk("t3_grant_count", 64'(gn), 64'd6);
    chk("t3_grant_order", 64'(gbits[5:0]), 64'b010101);
    for (int k = 0; k < 3; k++) begin
      chk_pkt(0, 4 * k, 32'h4000 * DW'(k + 1) + 32'd6);
      chk_pkt(1, 4 * k, 32'h40000 * DW'(k + 1) + 32'd6);
    end
    chk("t3_viol", 64'(viol), 64'd0);

    // Backpressure: M1_TREADY toggles, S1 has gaps. 80..83 -> sum 326.
    clr();
    tog_en = 1'b1;
    drive_s(1, 4, 32'd80, 1'b1);
    wait_words(1, 4);
    repeat (4) @(posedge aclk);
    #1;
    tog_en = 1'b0;
    chk_pkt(1, 0, 32'd326);
    chk("t4_no_extra_words", 64'(m1_d.size()), 64'd4);
    chk("t4_eng_hs_without_ready", 64'(bp_viol), 64'd0);
    chk("t4_viol", 64'(viol), 64'd0);

    // Short packet: 3 words with TLAST -> len_err rises on that handshake.
    clr();
    chk("t5_len_err_before", 64'(len_err), 64'd0);
    drive_s(0, 3, 32'd7, 1'b0);
    wait_words(0, 4);
    chk("t5_len_err_pre_edge", 64'(le_before), 64'd0);
    chk("t5_len_err_post_edge", 64'(le_after), 64'd1);
    chk_pkt(0, 0, 32'd24);
    chk("t5_busy_end", 64'(busy), 64'd0);
    drive_s(1, 4, 32'd0, 1'b0);
    wait_words(1, 4);
    chk_pkt(1, 0, 32'd6);
    chk("t5_len_err_sticky", 64'(len_err), 64'd1);

    // Reset during the second word of SEND, then a clean S1 request.
    clr();
    begin
      int t = 0;
      set_s(0, 1'b1, 32'd5, 1'b0);
      while (!S0_AXIS_TREADY && t < 50) begin @(negedge aclk); t++; end
      @(posedge aclk); #1;
      set_s(0, 1'b1, 32'd6, 1'b0);
      @(negedge aclk); #2;
      chk("t6_pre_reset_busy", 64'(busy), 64'd1);
      areset = 1'b1;
      #1;
      chk("t6_async_busy", 64'(busy), 64'd0);
      chk("t6_async_len_err", 64'(len_err), 64'd0);
      chk("t6_async_hs_vec", 64'(hs_vec()), 64'd0);
      set_s(0, 1'b0, '0, 1'b0);
      @(posedge aclk); #1;
      areset = 1'b0;
    end
    clr();
    drive_s(1, 4, 32'd32, 1'b0);
    wait_words(1, 4);
    chk_pkt(1, 0, 32'd134);
    chk("t6_m0_words", 64'(m0_d.size()), 64'd0);
    chk("t6_len_err", 64'(len_err), 64'd0);
    chk("t6_viol", 64'(viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
